sine_sweep_ctrl: RTL and testbench
==================================

SINE_SWEEP_CTRL -- requirements
Module: sine_sweep_ctrl

Interface
REQ-001 SHALL have parameter INC_W, default 16: phase-increment width driven to the sine NCO.
REQ-002 SHALL have parameter DWELL_W, default 8: dwell-counter width.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port cfg_valid  input  1: config write request.
REQ-006 SHALL have port cfg_ready  output  1: config write acceptance.
REQ-007 SHALL have port cfg_addr  input  3: register address.
REQ-008 SHALL have port cfg_data  input  8: write data.
REQ-009 SHALL have port phase_inc  output  INC_W: current NCO phase increment (registered).
REQ-010 SHALL have port nco_en  output  1: NCO run enable (registered).
REQ-011 SHALL have port inc_upd  output  1: one-cycle pulse on the cycle phase_inc takes a new value.
REQ-012 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-013 SHALL have port done  output  1: one-cycle pulse at sweep completion.

Function
REQ-014 SHALL accept a write on a rising edge where cfg_valid and cfg_ready are both high.
REQ-015 SHALL decode addresses as: 0 START_LO, 1 START_HI, 2 STOP_LO, 3 STOP_HI, 4 STEP, 5 DWELL, 6 MODE (bit0 loop, bit1 updown), 7 CMD (bit0 start, bit1 abort).
REQ-016 SHALL drive cfg_ready combinationally: 1 in IDLE; 0 while busy unless cfg_addr==7.
REQ-017 SHALL implement states IDLE, DWELL, STEP, DONE.
REQ-018 SHALL, on a CMD start in IDLE, on the next edge set phase_inc=START, nco_en=1, pulse inc_upd, load the dwell counter with DWELL, and enter DWELL.
REQ-019 SHALL set sweep direction up when START<=STOP and down otherwise, with target=STOP.
REQ-020 SHALL decrement the dwell counter each cycle in DWELL and enter STEP when it reaches 0.
REQ-021 SHALL give each frequency a hold period of DWELL+2 cycles: DWELL for DWELL+1 cycles, then STEP for 1 cycle.
REQ-022 SHALL, in STEP when phase_inc!=target, move phase_inc toward target by STEP (zero-extended; STEP=0 treated as 1), saturating at target with no wrap, pulse inc_upd, reload the dwell counter, and return to DWELL.
REQ-023 SHALL, in STEP when phase_inc==target, branch on MODE:
- loop=0: enter DONE.
- loop=1, updown=0: reload START with an inc_upd pulse (no pulse if START==STOP).
- loop=1, updown=1: swap target between START and STOP, reverse direction, and take a step.
REQ-024 SHALL, in DONE, pulse done for one cycle and return to IDLE; phase_inc and nco_en SHALL hold their final values.
REQ-025 SHALL, on a CMD abort in any state, on the next edge enter IDLE with phase_inc=0 and nco_en=0, and SHALL NOT pulse done; abort SHALL win over a simultaneous start.
REQ-026 SHALL ignore a CMD start while busy.
REQ-027 SHALL, when START==STOP, hold for one period and then follow REQ-023.

Reset
REQ-028 SHALL, while rst is high at an edge, clear all config registers, phase_inc, nco_en, inc_upd, done and the dwell counter, and set state to IDLE; busy=0 and cfg_ready=1 after reset.
REQ-029 SHALL treat reset mid-sweep identically: all outputs 0 on the next edge, with no done pulse.

Structure
REQ-030 SHALL place the state enum, the register address constants and the MODE/CMD bit positions in shared package sine_ctrl_pkg.
REQ-031 SHALL isolate the register file and write handshake in one sub-module, sine_cfg_regs; the FSM and stepper SHALL remain in sine_sweep_ctrl.

Verification
REQ-032 SHALL cover up-sweep: START=100, STOP=130, STEP=10, DWELL=2, MODE=0 -> phase_inc 100,110,120,130, each held 4 cycles; 4 inc_upd pulses; done one cycle after the last hold; busy falls with done.
REQ-033 SHALL cover saturation and step 0: START=100, STOP=125, STEP=10 -> 100,110,120,125, done; separately START=0, STOP=2, STEP=0 -> 0,1,2, done; START=STOP=0xFFFF -> no wrap, done after one period.
REQ-034 SHALL cover down-sweep ping-pong: START=50, STOP=20, STEP=15, MODE=3 -> 50,35,20,35,50,35... continuing; abort -> next edge phase_inc=0, nco_en=0, busy=0, no done.
REQ-035 SHALL cover handshake: write addr 4 while busy -> cfg_ready=0 and STEP unchanged after the sweep; CMD start while busy -> sequence unaffected; simultaneous start+abort in IDLE -> remains IDLE.
REQ-036 SHALL cover reset mid-sweep: rst high one cycle during DWELL -> next edge all outputs 0, cfg_ready=1, registers read back 0 (a new start uses 0 values).

Source files
------------

// File: rtl/sine_sweep_ctrl_pkg.sv
// sine_ctrl_pkg: shared state enum, register map and MODE/CMD bit positions for the sweep controller
package sine_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DWELL, STEP, DONE} state_t;
  localparam logic [2:0] A_START_LO = 3'd0;
  localparam logic [2:0] A_START_HI = 3'd1;
  localparam logic [2:0] A_STOP_LO  = 3'd2;
  localparam logic [2:0] A_STOP_HI  = 3'd3;
  localparam logic [2:0] A_STEP     = 3'd4;
  localparam logic [2:0] A_DWELL    = 3'd5;
  localparam logic [2:0] A_MODE     = 3'd6;
  localparam logic [2:0] A_CMD      = 3'd7;
  localparam int MODE_LOOP   = 0;
  localparam int MODE_UPDOWN = 1;
  localparam int CMD_START   = 0;
  localparam int CMD_ABORT   = 1;
endpackage

// File: rtl/sine_sweep_ctrl_if.sv
// sine_cfg_if: config write bus (valid/ready handshake, address, data)
interface sine_cfg_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  modport master (output cfg_valid, cfg_addr, cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, cfg_addr, cfg_data, output cfg_ready);
endinterface

// File: rtl/sine_sweep_ctrl_cfg_regs.sv
// sine_cfg_regs: register file and write handshake; CMD writes become one-cycle start/abort strobes
module sine_cfg_regs
  import sine_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        busy,
  sine_cfg_if.slave   cfg,
  output logic [15:0] start,
  output logic [15:0] stop,
  output logic [7:0]  step,
  output logic [7:0]  dwell,
  output logic [1:0]  mode,
  output logic        cmd_start,
  output logic        cmd_abort
);
  logic [7:0] regs_q [6];
  logic [7:0] regs_d [6];
  logic [1:0] mode_q, mode_d;
  logic       we;
  always_comb begin
    cfg.cfg_ready = !busy || cfg.cfg_addr == A_CMD;
    we = cfg.cfg_valid && cfg.cfg_ready;
    regs_d = regs_q;
    for (int i = 0; i < 6; i++) regs_d[i] = (we && cfg.cfg_addr == 3'(i)) ? cfg.cfg_data : regs_q[i];
    mode_d = (we && cfg.cfg_addr == A_MODE) ? cfg.cfg_data[1:0] : mode_q;
    cmd_start = we && cfg.cfg_addr == A_CMD && cfg.cfg_data[CMD_START];
    cmd_abort = we && cfg.cfg_addr == A_CMD && cfg.cfg_data[CMD_ABORT];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      mode_q <= '0;
    end else begin
      regs_q <= regs_d;
      mode_q <= mode_d;
    end
  end
  assign start = {regs_q[A_START_HI], regs_q[A_START_LO]};
  assign stop  = {regs_q[A_STOP_HI], regs_q[A_STOP_LO]};
  assign step  = regs_q[A_STEP];
  assign dwell = regs_q[A_DWELL];
  assign mode  = mode_q;
endmodule

// File: rtl/sine_sweep_ctrl.sv
// sine_sweep_ctrl: steps an NCO phase increment from START to STOP, holding each value DWELL+2 cycles
module sine_sweep_ctrl
  import sine_ctrl_pkg::*;
#(
  parameter int INC_W   = 16,
  parameter int DWELL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  sine_cfg_if.slave        cfg,
  output logic [INC_W-1:0] phase_inc,
  output logic             nco_en,
  output logic             inc_upd,
  output logic             busy,
  output logic             done
);
  state_t             state_q, state_d;
  logic [INC_W-1:0]   phase_q, phase_d, tgt_q, tgt_d, start_i, stop_i, s;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               nco_q, nco_d, upd_q, upd_d, done_q, done_d;
  logic [15:0]        start_r, stop_r;
  logic [7:0]         step_r, dwell_r;
  logic [1:0]         mode_r;
  logic               cmd_start, cmd_abort;
  sine_cfg_regs u_regs (
    .clk(clk), .rst(rst), .busy(busy), .cfg(cfg),
    .start(start_r), .stop(stop_r), .step(step_r), .dwell(dwell_r), .mode(mode_r),
    .cmd_start(cmd_start), .cmd_abort(cmd_abort)
  );
  // direction is implied by which side of the target phase sits; saturate instead of overshooting
  function automatic logic [INC_W-1:0] toward(input logic [INC_W-1:0] p, t, st);
    return p < t ? ((t - p <= st) ? t : p + st) : ((p - t <= st) ? t : p - st);
  endfunction
  always_comb begin
    start_i = INC_W'(start_r);
    stop_i  = INC_W'(stop_r);
    s       = step_r == '0 ? INC_W'(1) : INC_W'(step_r);
    state_d = state_q;
    phase_d = phase_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    nco_d   = nco_q;
    upd_d   = 1'b0;
    if (cmd_abort) begin
      state_d = IDLE;
      phase_d = '0;
      nco_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_start) begin
          state_d = DWELL;
          phase_d = start_i;
          tgt_d   = stop_i;
          cnt_d   = DWELL_W'(dwell_r);
          nco_d   = 1'b1;
          upd_d   = 1'b1;
        end
        DWELL: begin
          state_d = cnt_q == '0 ? STEP : DWELL;
          cnt_d   = cnt_q - 1'b1;
        end
        STEP: begin
          state_d = DWELL;
          cnt_d   = DWELL_W'(dwell_r);
          if (phase_q != tgt_q) phase_d = toward(phase_q, tgt_q, s);
          else if (!mode_r[MODE_LOOP]) state_d = DONE;
          else if (!mode_r[MODE_UPDOWN]) phase_d = start_i;
          else begin
            tgt_d   = tgt_q == stop_i ? start_i : stop_i;
            phase_d = toward(phase_q, tgt_d, s);
          end
          upd_d = phase_d != phase_q;
        end
        default: state_d = IDLE;
      endcase
    end
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      nco_q   <= 1'b0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      nco_q   <= nco_d;
      upd_q   <= upd_d;
      done_q  <= done_d;
    end
  end
  assign phase_inc = phase_q;
  assign nco_en    = nco_q;
  assign inc_upd   = upd_q;
  assign done      = done_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// tb_sine_sweep_ctrl: directed checks of the sine sweep controller with hand-computed phase sequences
module tb_sine_sweep_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] phase_inc;
  logic        nco_en, inc_upd, busy, done;
  int          passed = 0, total = 0, fails = 0;
  logic [15:0] exp_q [$];
  sine_cfg_if cfg_if ();
  sine_sweep_ctrl dut (
    .clk(clk), .rst(rst), .cfg(cfg_if),
    .phase_inc(phase_inc), .nco_en(nco_en), .inc_upd(inc_upd), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = a;
    cfg_if.cfg_data  = d;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask
  task automatic setup(input logic [15:0] st, sp, input logic [7:0] stp, dw, md);
    wr(3'd0, st[7:0]);
    wr(3'd1, st[15:8]);
    wr(3'd2, sp[7:0]);
    wr(3'd3, sp[15:8]);
    wr(3'd4, stp);
    wr(3'd5, dw);
    wr(3'd6, md);
  endtask
  task automatic sweep(input string tag, input int per, input bit fin);
    int ups = 0;
    for (int i = 0; i < exp_q.size() * per; i++) begin
      if (i > 0) tick();
      chk({tag, "_phase"}, phase_inc, exp_q[i / per]);
      ups += int'(inc_upd);
    end
    chk({tag, "_upd_cnt"}, ups, exp_q.size());
    if (fin) begin
      tick();
      chk({tag, "_done"}, done, 1);
      tick();
      chk({tag, "_done_1cyc"}, done, 0);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_nco_hold"}, nco_en, 1);
      chk({tag, "_phase_hold"}, phase_inc, exp_q[exp_q.size() - 1]);
    end
  endtask
  initial begin
    int dn;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_addr  = '0;
    cfg_if.cfg_data  = '0;
    repeat (2) tick();
    chk("rst_phase", phase_inc, 0);
    chk("rst_nco", nco_en, 0);
    chk("rst_upd", inc_upd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    rst = 1'b0;
    setup(16'd100, 16'd130, 8'd10, 8'd2, 8'd0);
    wr(3'd7, 8'h01);
    exp_q = '{16'd100, 16'd110, 16'd120, 16'd130};
    sweep("up", 4, 1'b1);
    setup(16'd100, 16'd125, 8'd10, 8'd2, 8'd0);
    wr(3'd7, 8'h01);
    exp_q = '{16'd100, 16'd110, 16'd120, 16'd125};
    sweep("sat", 4, 1'b1);
    setup(16'd0, 16'd2, 8'd0, 8'd2, 8'd0);
    wr(3'd7, 8'h01);
    exp_q = '{16'd0, 16'd1, 16'd2};
    sweep("step0", 4, 1'b1);
    setup(16'hFFFF, 16'hFFFF, 8'd10, 8'd2, 8'd0);
    wr(3'd7, 8'h01);
    exp_q = '{16'hFFFF};
    sweep("max", 4, 1'b1);
    setup(16'd50, 16'd20, 8'd15, 8'd2, 8'd3);
    wr(3'd7, 8'h01);
    exp_q = '{16'd50, 16'd35, 16'd20, 16'd35, 16'd50, 16'd35, 16'd20};
    sweep("pingpong", 4, 1'b0);
    wr(3'd7, 8'h02);
    chk("abort_phase", phase_inc, 0);
    chk("abort_nco", nco_en, 0);
    chk("abort_busy", busy, 0);
    dn = int'(done);
    repeat (6) begin
      tick();
      dn += int'(done);
    end
    chk("abort_no_done", dn, 0);
    setup(16'd10, 16'd30, 8'd10, 8'd0, 8'd1);
    wr(3'd7, 8'h01);
    exp_q = '{16'd10, 16'd20, 16'd30, 16'd10, 16'd20};
    sweep("loop", 2, 1'b0);
    wr(3'd7, 8'h02);
    chk("loop_abort_busy", busy, 0);
    setup(16'd100, 16'd130, 8'd10, 8'd2, 8'd0);
    wr(3'd7, 8'h01);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = 3'd4;
    cfg_if.cfg_data  = 8'd99;
    #1 chk("busy_ready_step", cfg_if.cfg_ready, 0);
    tick();
    @(negedge clk);
    cfg_if.cfg_addr = 3'd7;
    cfg_if.cfg_data = 8'h01;
    #1 chk("busy_ready_cmd", cfg_if.cfg_ready, 1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    for (int k = 3; k <= 17; k++) begin
      tick();
      if (k == 15) chk("hs_phase_last", phase_inc, 130);
      if (k == 16) chk("hs_done", done, 1);
      if (k == 17) chk("hs_busy_end", busy, 0);
    end
    wr(3'd7, 8'h01);
    exp_q = '{16'd100, 16'd110, 16'd120, 16'd130};
    sweep("step_kept", 4, 1'b1);
    wr(3'd7, 8'h03);
    chk("startabort_busy", busy, 0);
    chk("startabort_nco", nco_en, 0);
    chk("startabort_upd", inc_upd, 0);
    wr(3'd7, 8'h01);
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_phase", phase_inc, 0);
    chk("mrst_nco", nco_en, 0);
    chk("mrst_upd", inc_upd, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_ready", cfg_if.cfg_ready, 1);
    wr(3'd7, 8'h01);
    exp_q = '{16'd0};
    sweep("zero_regs", 2, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
